// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader: FSM encodings and the
// bit-count width helper.
package serial_word_loader_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_LOAD    = 2'd3;

  // Wide enough to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_word_loader_bit_counter.sv
// Frame bit counter: synchronous clear, load-to-one and increment, in that
// priority order.
module bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (load1)
      cnt <= W'(1);
    else if (inc)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/serial_word_loader.sv
// Deserialises a framed serial stream into an N-bit word on D, then pulses En
// one cycle after D settles so the downstream gated register never sees D move.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         Clk,
  input  logic         R,
  input  logic         SIn,
  input  logic         SValid,
  input  logic         SStart,
  output logic         SReady,
  output logic [N-1:0] D,
  output logic         En,
  output logic         Busy,
  output logic         FrameErr
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  sr;
  logic [N-1:0]  sr_base;
  logic [N-1:0]  sr_nxt;
  logic          accept;
  logic          frame_bit;
  logic          complete;

  assign SReady    = ~R & ((state == ST_IDLE) | (state == ST_SHIFT));
  assign Busy      = (state != ST_IDLE);
  assign accept    = SValid & SReady;
  // In IDLE only a start-qualified bit opens a frame; anything else is dropped.
  assign frame_bit = accept & (SStart | (state == ST_SHIFT));
  assign complete  = frame_bit & (SStart ? (N == 1) : (cnt == LAST_CNT));
  assign sr_base   = SStart ? '0 : sr;

  generate
    if (N == 1) begin : g_single
      always_comb sr_nxt = SIn;
    end else begin : g_multi
      always_comb begin
        if (MSB_FIRST != 0)
          sr_nxt = {sr_base[N-2:0], SIn};
        else
          sr_nxt = {SIn, sr_base[N-1:1]};
      end
    end
  endgenerate

  bit_counter #(.W(CW)) u_bit_counter (
    .clk   (Clk),
    .clr   (R | complete),
    .load1 (frame_bit & SStart),
    .inc   (frame_bit & ~SStart),
    .cnt   (cnt)
  );

  always_ff @(posedge Clk) begin
    if (R) begin
      state    <= ST_IDLE;
      sr       <= '0;
      D        <= '0;
      En       <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      En       <= 1'b0;
      FrameErr <= 1'b0;
      case (state)
        ST_IDLE, ST_SHIFT: begin
          if (frame_bit) begin
            sr       <= sr_nxt;
            FrameErr <= SStart & (state == ST_SHIFT);
            if (complete) begin
              D     <= sr_nxt;
              state <= ST_PRESENT;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        // D has been stable for one full cycle here; release the load enable.
        ST_PRESENT: begin
          En    <= 1'b1;
          state <= ST_LOAD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench: unit 0 is N=8 MSB-first, unit 1 is N=8 LSB-first, unit 2 is N=1.
module tb_serial_word_loader;

  logic       clk = 1'b0;
  logic [2:0] r       = 3'b111;
  logic [2:0] s_in    = 3'b000;
  logic [2:0] s_valid = 3'b000;
  logic [2:0] s_start = 3'b000;
  logic [2:0] s_ready, en, busy, ferr;
  logic [7:0] d0, d1;
  logic [0:0] d2;
  logic [7:0] dv [3];

  int checks = 0;
  int errs   = 0;
  logic [7:0] exp_q [3][$];
  int   ferr_cnt [3];
  logic [7:0] prev_d [3];
  logic       prev_en [3];
  logic       prev_r [3];

  always #5 clk = ~clk;

  serial_word_loader #(.N(8), .MSB_FIRST(1)) u0 (
    .Clk(clk), .R(r[0]), .SIn(s_in[0]), .SValid(s_valid[0]), .SStart(s_start[0]),
    .SReady(s_ready[0]), .D(d0), .En(en[0]), .Busy(busy[0]), .FrameErr(ferr[0]));
  serial_word_loader #(.N(8), .MSB_FIRST(0)) u1 (
    .Clk(clk), .R(r[1]), .SIn(s_in[1]), .SValid(s_valid[1]), .SStart(s_start[1]),
    .SReady(s_ready[1]), .D(d1), .En(en[1]), .Busy(busy[1]), .FrameErr(ferr[1]));
  serial_word_loader #(.N(1), .MSB_FIRST(1)) u2 (
    .Clk(clk), .R(r[2]), .SIn(s_in[2]), .SValid(s_valid[2]), .SStart(s_start[2]),
    .SReady(s_ready[2]), .D(d2), .En(en[2]), .Busy(busy[2]), .FrameErr(ferr[2]));

  assign dv[0] = d0;
  assign dv[1] = d1;
  assign dv[2] = {7'b0, d2};

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input int u, input bit v, input bit b, input bit st);
    s_valid[u] = v;
    s_in[u]    = b;
    s_start[u] = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int u, input int n);
    for (int i = 0; i < n; i++) drive(u, 1'b0, 1'b0, 1'b0);
  endtask

  // bits[n-1] goes out first; gap idle cycles follow every bit but the last.
  task automatic send_stream(input int u, input int n, input logic [7:0] bits, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      drive(u, 1'b1, bits[i], i == n - 1);
      if (i != 0) idle(u, gap);
    end
    s_valid[u] = 1'b0;
    s_start[u] = 1'b0;
  endtask

  // Monitor: D may only move to the next expected word; En pops and checks it.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (!r[u] && !prev_r[u]) begin
        if (dv[u] !== prev_d[u]) begin
          checks++;
          if (exp_q[u].size() == 0 || dv[u] !== exp_q[u][0]) begin
            errs++;
            $display("FAIL d_change u%0d got %h expected %h", u, dv[u],
                     (exp_q[u].size() == 0) ? 8'h00 : exp_q[u][0]);
          end
        end
        if (en[u]) begin
          checks++;
          if (exp_q[u].size() == 0) begin
            errs++;
            $display("FAIL unexpected_en u%0d got d=%h expected no En", u, dv[u]);
          end else begin
            logic [7:0] w;
            w = exp_q[u].pop_front();
            if (dv[u] !== w) begin
              errs++;
              $display("FAIL en_word u%0d got %h expected %h", u, dv[u], w);
            end
          end
          checks++;
          if (prev_en[u] || dv[u] !== prev_d[u]) begin
            errs++;
            $display("FAIL en_stable u%0d got prev_en=%0b prev_d=%h d=%h expected single En with stable D",
                     u, prev_en[u], prev_d[u], dv[u]);
          end
        end
      end
      if (ferr[u] === 1'b1) ferr_cnt[u]++;
      prev_d[u]  = dv[u];
      prev_en[u] = en[u];
      prev_r[u]  = r[u];
    end
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      ferr_cnt[u] = 0;
      prev_d[u]   = 8'h00;
      prev_en[u]  = 1'b0;
      prev_r[u]   = 1'b1;
    end

    // Reset held two cycles with SValid asserted
    r = 3'b111;
    s_valid = 3'b111;
    s_start = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_d_u%0d", u), dv[u], 8'h00);
      chk($sformatf("rst_en_u%0d", u), {7'b0, en[u]}, 8'h00);
      chk($sformatf("rst_ready_u%0d", u), {7'b0, s_ready[u]}, 8'h00);
      chk($sformatf("rst_busy_u%0d", u), {7'b0, busy[u]}, 8'h00);
    end
    r = 3'b000;
    s_valid = 3'b000;
    s_start = 3'b000;
    #1;
    chk("post_rst_ready", {5'b0, s_ready}, 8'h07);
    @(posedge clk);
    #1;

    // MSB-first back-to-back frame
    exp_q[0].push_back(8'hB2);
    send_stream(0, 8, 8'hB2, 0);
    chk("k_d", d0, 8'hB2);
    chk("k_en", {7'b0, en[0]}, 8'h00);
    chk("k_ready", {7'b0, s_ready[0]}, 8'h00);
    chk("k_busy", {7'b0, busy[0]}, 8'h01);
    idle(0, 1);
    chk("k1_en", {7'b0, en[0]}, 8'h01);
    chk("k1_ready", {7'b0, s_ready[0]}, 8'h00);
    idle(0, 1);
    chk("k2_en", {7'b0, en[0]}, 8'h00);
    chk("k2_ready", {7'b0, s_ready[0]}, 8'h01);
    chk("k2_busy", {7'b0, busy[0]}, 8'h00);

    // LSB-first, then the same stream with gaps
    exp_q[1].push_back(8'h4D);
    send_stream(1, 8, 8'hB2, 0);
    chk("lsb_d", d1, 8'h4D);
    idle(1, 3);
    exp_q[1].push_back(8'h4D);
    send_stream(1, 8, 8'hB2, 2);
    chk("lsb_gap_d", d1, 8'h4D);
    idle(1, 3);

    // Restart mid-frame
    exp_q[0].push_back(8'hFF);
    send_stream(0, 3, 8'h05, 0);
    send_stream(0, 8, 8'hFF, 0);
    chk("restart_d", d0, 8'hFF);
    idle(0, 3);

    // Reset while in PRESENT, then start-less bits in IDLE
    exp_q[1].push_back(8'hA5);
    send_stream(1, 8, 8'hA5, 0);
    chk("pre_abort_d", d1, 8'hA5);
    r[1] = 1'b1;
    idle(1, 1);
    chk("abort_en", {7'b0, en[1]}, 8'h00);
    chk("abort_d", d1, 8'h00);
    chk("abort_busy", {7'b0, busy[1]}, 8'h00);
    r[1] = 1'b0;
    void'(exp_q[1].pop_front());
    idle(1, 2);
    chk("abort_en_later", {7'b0, en[1]}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, 1'b1, 1'b0);
      chk("nostart_busy", {7'b0, busy[1]}, 8'h00);
    end
    s_valid[1] = 1'b0;
    idle(1, 2);
    chk("nostart_d", d1, 8'h00);

    // N=1: two frames three cycles apart
    exp_q[2].push_back(8'h01);
    exp_q[2].push_back(8'h00);
    drive(2, 1'b1, 1'b1, 1'b1);
    chk("n1_k_d", dv[2], 8'h01);
    chk("n1_k_ready", {7'b0, s_ready[2]}, 8'h00);
    drive(2, 1'b1, 1'b0, 1'b1);
    chk("n1_k1_en", {7'b0, en[2]}, 8'h01);
    chk("n1_k1_d", dv[2], 8'h01);
    drive(2, 1'b1, 1'b0, 1'b1);
    chk("n1_k2_en", {7'b0, en[2]}, 8'h00);
    chk("n1_k2_d", dv[2], 8'h01);
    chk("n1_k2_ready", {7'b0, s_ready[2]}, 8'h01);
    drive(2, 1'b1, 1'b0, 1'b1);
    s_valid[2] = 1'b0;
    s_start[2] = 1'b0;
    chk("n1_k3_d", dv[2], 8'h00);
    idle(2, 3);

    for (int u = 0; u < 3; u++)
      chk($sformatf("q_empty_u%0d", u), 8'(exp_q[u].size()), 8'h00);
    chk("ferr_u0", 8'(ferr_cnt[0]), 8'h01);
    chk("ferr_u1", 8'(ferr_cnt[1]), 8'h00);
    chk("ferr_u2", 8'(ferr_cnt[2]), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
